// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory load controller.
// Default widths follow the def.h values; the patch port is enabled by IMEM_PATCH_EN.
package imem_ctrl_pkg;

  localparam int IMEM_ADDR_W_D = 5;

  localparam int IMEM_W_D = 32;

  localparam logic [31:0] IMEM_NOP = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    RUN  = 2'd3
  } state_t;

endpackage

// File: rtl/imem_port_mux.sv
// Combinational owner selection for the single imem port and the instruction returned to fetch.
// Optional patch writer (IMEM_PATCH_EN) pre-empts fetch while running.
module imem_port_mux
  import imem_ctrl_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W_D,
  parameter int DATA_W = IMEM_W_D,
  parameter int DEPTH  = 10
) (
  input  logic              in_load,
  input  logic              in_run,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef IMEM_PATCH_EN
  input  logic              patch_valid,
  input  logic [ADDR_W-1:0] patch_addr,
  input  logic [DATA_W-1:0] patch_data,
`endif
  output logic              patch_grant,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] cpu_instr
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic fetch_ok;
  assign fetch_ok = ({1'b0, cpu_addr} < DEPTH_W);

`ifdef IMEM_PATCH_EN
  assign patch_grant = in_run & patch_valid;
`else
  assign patch_grant = 1'b0;
`endif

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_instr = DATA_W'(IMEM_NOP);
    if (in_load && ld_valid) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = ld_data;
`ifdef IMEM_PATCH_EN
    end else if (patch_grant) begin
      // Out-of-range patches still steal the cycle but never touch the array.
      if ({1'b0, patch_addr} < DEPTH_W) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = patch_addr;
        mem_wdata = patch_data;
      end
`endif
    end else if (in_run && fetch_ok) begin
      mem_en    = 1'b1;
      mem_addr  = cpu_addr;
      cpu_instr = mem_rdata;
    end
  end

endmodule

// File: rtl/imem_load_ctrl.sv
// Boot-time loader / fetch arbiter for the instruction memory: IDLE -> LOAD -> DONE -> RUN.
// Define IMEM_PATCH_EN to add the run-time patch write port.
module imem_load_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W_D,
  parameter int DATA_W    = IMEM_W_D,
  parameter int DEPTH     = 10,
  parameter bit START_RUN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_done,
  output logic              ld_err,
  output logic [ADDR_W:0]   ld_count,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_instr,
  output logic              cpu_stall,
`ifdef IMEM_PATCH_EN
  input  logic              patch_valid,
  input  logic [ADDR_W-1:0] patch_addr,
  input  logic [DATA_W-1:0] patch_data,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] wr_addr;
  logic              accept, restart, patch_grant;

  assign accept  = (state == LOAD) && ld_valid;
  assign restart = ld_start && ((state == IDLE) || (state == RUN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= START_RUN ? RUN : IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (ld_start) state_nx = LOAD;
      LOAD: if (accept && (ld_last || wr_addr == LAST_ADDR)) state_nx = DONE;
      DONE: state_nx = RUN;
      RUN:  if (ld_start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ld_ready  = (state == LOAD);
    ld_done   = (state == DONE);
    cpu_stall = (state != RUN) || patch_grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      ld_count <= '0;
      ld_err   <= 1'b0;
    end else if (restart) begin
      wr_addr  <= '0;
      ld_count <= '0;
      ld_err   <= 1'b0;
    end else if (accept) begin
      wr_addr <= wr_addr + ADDR_W'(1);
      if (ld_count != DEPTH_W) ld_count <= ld_count + (ADDR_W+1)'(1);
      // Filling the last slot without ld_last means the program did not fit.
      if (!ld_last && wr_addr == LAST_ADDR) ld_err <= 1'b1;
    end
  end

  imem_port_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mux (
    .in_load    (state == LOAD),
    .in_run     (state == RUN),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .wr_addr    (wr_addr),
    .cpu_addr   (cpu_addr),
    .mem_rdata  (mem_rdata),
`ifdef IMEM_PATCH_EN
    .patch_valid(patch_valid),
    .patch_addr (patch_addr),
    .patch_data (patch_data),
`endif
    .patch_grant(patch_grant),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_instr  (cpu_instr)
  );

endmodule
